// File: rtl/router_out_ctrl.sv
// rtl/router_out_ctrl.sv - output-port reader: FIFO pop, packet framing, client handshake, drain timeout
// Captured bytes land in a 2-entry buffer whose head drives the client; a stalled client flushes the port.
module router_out_ctrl #(
   parameter int TIMEOUT = 30,
   parameter int DEPTH   = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_read_enb,
   output logic       soft_reset,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_sop,
   output logic       out_eop,
   output logic       out_perr
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
   localparam logic [CW-1:0] TMO_M1  = CW'(TIMEOUT - 1);
   localparam logic [1:0]    DEPTH_C = 2'(DEPTH);

   typedef enum logic [1:0] {
      S_HDR = 2'd0,
      S_PLD = 2'd1,
      S_PAR = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [5:0]    remaining_q;
   logic [7:0]    parity_q;
   logic [10:0]   mem_q [2];
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [1:0]    occ_q;
   logic [1:0]    occ_after;
   logic          inflight_q;
   logic [CW-1:0] stall_q;
   logic          push;
   logic          pop;
   logic          stalled;
   logic          tag_sop;
   logic          tag_eop;
   logic          tag_perr;
   logic [10:0]   head;

   // A capture landing in the flush cycle is dropped along with the buffer.
   assign push      = inflight_q && !soft_reset;
   assign pop       = out_valid && out_ready;
   assign stalled   = out_valid && !out_ready;
   assign occ_after = occ_q + {1'b0, push} - {1'b0, pop};

   assign fifo_read_enb = resetn && !fifo_empty && !soft_reset && (occ_after < DEPTH_C);

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = out_valid ? head[7:0] : 8'd0;
   assign out_perr  = out_valid && head[8];
   assign out_eop   = out_valid && head[9];
   assign out_sop   = out_valid && head[10];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         occ_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         inflight_q <= 1'b0;
         mem_q[0]   <= 11'd0;
         mem_q[1]   <= 11'd0;
      end else if (soft_reset) begin
         occ_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {tag_sop, tag_eop, tag_perr, fifo_dout};
         end
         wr_ptr_q   <= wr_ptr_q ^ push;
         rd_ptr_q   <= rd_ptr_q ^ pop;
         occ_q      <= occ_after;
         inflight_q <= fifo_read_enb;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_HDR;
      end else if (soft_reset) begin
         state_q <= S_HDR;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (push) begin
         case (state_q)
            S_HDR:   state_d = (fifo_dout[7:2] != 6'd0) ? S_PLD : S_PAR;
            S_PLD:   if (remaining_q == 6'd1) state_d = S_PAR;
            S_PAR:   state_d = S_HDR;
            default: state_d = S_HDR;
         endcase
      end
   end

   always_comb begin
      tag_sop  = 1'b0;
      tag_eop  = 1'b0;
      tag_perr = 1'b0;
      case (state_q)
         S_HDR: tag_sop = 1'b1;
         S_PAR: begin
            tag_eop  = 1'b1;
            tag_perr = (fifo_dout != parity_q);
         end
         default: ;
      endcase
   end

   // Header address bits are folded into parity but otherwise passed through.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         remaining_q <= 6'd0;
         parity_q    <= 8'd0;
      end else if (soft_reset) begin
         remaining_q <= 6'd0;
         parity_q    <= 8'd0;
      end else if (push) begin
         case (state_q)
            S_HDR: begin
               remaining_q <= fifo_dout[7:2];
               parity_q    <= fifo_dout;
            end
            S_PLD: begin
               remaining_q <= remaining_q - 6'd1;
               parity_q    <= parity_q ^ fifo_dout;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_q    <= '0;
         soft_reset <= 1'b0;
      end else if (soft_reset || !stalled) begin
         stall_q    <= '0;
         soft_reset <= 1'b0;
      end else begin
         if (stall_q != TMO) begin
            stall_q <= stall_q + 1'b1;
         end
         soft_reset <= (stall_q == TMO_M1);
      end
   end

endmodule

// File: tb/tb_router_out_ctrl.sv
// tb/tb_router_out_ctrl.sv - table, corner-case and random checks of router_out_ctrl
// A queue-based FIFO and a packet-position model supply every expected beat.
module tb_router_out_ctrl;
   localparam int TIMEOUT = 30;

   logic       clk = 1'b0;
   logic       resetn;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_read_enb;
   logic       soft_reset;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;
   logic       out_perr;

   always #5 clk = ~clk;

   router_out_ctrl #(.TIMEOUT(TIMEOUT), .DEPTH(2)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .fifo_empty    (fifo_empty),
      .fifo_dout     (fifo_dout),
      .fifo_read_enb (fifo_read_enb),
      .soft_reset    (soft_reset),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_sop       (out_sop),
      .out_eop       (out_eop),
      .out_perr      (out_perr)
   );

   typedef struct {
      logic [7:0] hdr;
      logic       bad;
      int         beats;
      logic       perr;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  fq[$];
   logic [10:0] exp_q[$];
   int          m_pos;
   int          m_len;
   logic [7:0]  m_par;
   int          stall_run;
   logic        prev_sr;
   logic        rd_seen, valid_seen, sr_seen, pop_seen, rd_en_seen;
   logic [10:0] pop_word;

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
      end
   endtask

   function automatic void model_reset();
      m_pos = 0;
      m_len = 0;
      m_par = 8'd0;
   endfunction

   // Position within the packet: 0 is the header, len+1 the parity byte.
   function automatic logic [10:0] model_tag(input logic [7:0] b);
      logic [10:0] e;
      if (m_pos == 0) begin
         m_len = int'(b[7:2]);
         m_par = b;
         e = {3'b100, b};
         m_pos = 1;
      end else if (m_pos == m_len + 1) begin
         e = {2'b01, (b != m_par), b};
         m_pos = 0;
      end else begin
         m_par = m_par ^ b;
         e = {3'b000, b};
         m_pos++;
      end
      return e;
   endfunction

   task automatic load_packet(input logic [7:0] hdr, input logic bad_par, input logic [7:0] salt);
      logic [7:0] p;
      logic [7:0] b;
      int         len;
      len = int'(hdr[7:2]);
      fq.push_back(hdr);
      p = hdr;
      for (int i = 0; i < len; i++) begin
         b = 8'((i + 1) * 17) + salt;
         fq.push_back(b);
         p = p ^ b;
      end
      fq.push_back(bad_par ? (p ^ 8'h01) : p);
      fifo_empty = 1'b0;
   endtask

   task automatic cycle();
      logic       acc;
      logic       pop;
      logic       sr;
      logic [7:0] b;
      int         held;
      @(negedge clk);
      acc        = fifo_read_enb && !fifo_empty;
      pop        = out_valid && out_ready;
      sr         = soft_reset;
      rd_seen    = acc;
      valid_seen = out_valid;
      sr_seen    = sr;
      pop_seen   = pop;
      rd_en_seen = fifo_read_enb;
      pop_word   = {out_sop, out_eop, out_perr, out_data};
      if (out_valid) begin
         if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
         else check("beat", int'(pop_word), int'(exp_q[0]));
      end
      check("soft_reset", int'(sr), int'(stall_run == TIMEOUT));
      if (sr) check("read_in_soft_reset", int'(fifo_read_enb), 0);
      if (prev_sr) check("valid_after_flush", int'(out_valid), 0);
      if (fifo_read_enb) begin
         held = exp_q.size() - int'(pop);
         check("read_with_full_buffer", int'(held >= 2), 0);
      end
      if (sr || !(out_valid && !out_ready)) stall_run = 0;
      else stall_run++;
      prev_sr = sr;
      @(posedge clk);
      #1;
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
         b = fq.pop_front();
         exp_q.push_back(model_tag(b));
         fifo_dout = b;
      end else begin
         fifo_dout = 8'($urandom);
      end
      if (sr) begin
         exp_q.delete();
         fq.delete();
         model_reset();
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic run_packet(input logic toggle, output int beats, output logic perr,
                             output logic sop1, output int lat, output logic done);
      int first_rd;
      int first_v;
      beats = 0; perr = 1'b0; sop1 = 1'b0; done = 1'b0;
      first_rd = -1; first_v = -1;
      for (int k = 0; k < 300 && !done; k++) begin
         if (toggle) out_ready = (k % 2 == 0);
         cycle();
         if (rd_seen && first_rd < 0) first_rd = k;
         if (valid_seen && first_v < 0) first_v = k;
         if (pop_seen) begin
            if (beats == 0) sop1 = pop_word[10];
            beats++;
            if (pop_word[9]) begin
               done = 1'b1;
               perr = pop_word[8];
            end
         end
      end
      lat = first_v - first_rd;
      if (!done) check("packet_completion", 0, 1);
   endtask

   initial begin
      vec_t tbl[6];
      int   beats, lat, k_v, k_s, pulses;
      logic perr, sop1, done;

      tbl[0] = '{8'h0C, 1'b0, 5, 1'b0};
      tbl[1] = '{8'h0C, 1'b1, 5, 1'b1};
      tbl[2] = '{8'h0C, 1'b0, 5, 1'b0};
      tbl[3] = '{8'h01, 1'b0, 2, 1'b0};
      tbl[4] = '{8'h02, 1'b1, 2, 1'b1};
      tbl[5] = '{8'hFF, 1'b0, 65, 1'b0};

      resetn = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'd0;
      model_reset(); stall_run = 0; prev_sr = 1'b0;
      fq.push_back(8'h0C); fifo_empty = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_read_enb", int'(fifo_read_enb), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_soft_reset", int'(soft_reset), 0);
      check("reset_outputs", int'({out_sop, out_eop, out_perr, out_data}), 0);
      fq.delete(); fifo_empty = 1'b1;
      resetn = 1'b1;

      out_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         load_packet(tbl[v].hdr, tbl[v].bad, 8'd0);
         run_packet(1'b0, beats, perr, sop1, lat, done);
         check("vec_beats", beats, tbl[v].beats);
         check("vec_perr", int'(perr), int'(tbl[v].perr));
         check("vec_first_sop", int'(sop1), 1);
         check("vec_latency", lat, 2);
      end

      load_packet(8'h28, 1'b0, 8'h05);
      run_packet(1'b1, beats, perr, sop1, lat, done);
      check("toggle_beats", beats, 12);
      check("toggle_perr", int'(perr), 0);
      out_ready = 1'b1;
      repeat (3) cycle();

      out_ready = 1'b0;
      load_packet(8'h0C, 1'b0, 8'd0);
      k_v = -1; k_s = -1; pulses = 0;
      for (int k = 0; k < 70; k++) begin
         cycle();
         if (valid_seen && k_v < 0) k_v = k;
         if (sr_seen) begin
            pulses++;
            if (k_s < 0) begin
               k_s = k;
               check("tmo_read_enb_in_pulse", int'(rd_en_seen), 0);
            end
         end
         if (k_s >= 0 && k == k_s + 1) check("tmo_valid_after", int'(valid_seen), 0);
      end
      check("tmo_pulses", pulses, 1);
      check("tmo_delay", k_s - k_v, TIMEOUT);
      out_ready = 1'b1;
      repeat (4) cycle();
      check("tmo_fifo_flushed", fq.size(), 0);

      load_packet(8'h28, 1'b0, 8'h40);
      repeat (6) cycle();
      check("pre_reset_valid", int'(out_valid), 1);
      check("pre_reset_read", int'(fifo_read_enb), 1);
      resetn = 1'b0;
      #1;
      check("async_reset_valid", int'(out_valid), 0);
      check("async_reset_read", int'(fifo_read_enb), 0);
      check("async_reset_soft", int'(soft_reset), 0);
      exp_q.delete(); fq.delete(); fifo_empty = 1'b1;
      model_reset(); stall_run = 0; prev_sr = 1'b0;
      repeat (2) cycle();
      resetn = 1'b1;
      load_packet(8'h0C, 1'b0, 8'h09);
      run_packet(1'b0, beats, perr, sop1, lat, done);
      check("post_reset_sop", int'(sop1), 1);
      check("post_reset_beats", beats, 5);

      for (int c = 0; c < 2000; c++) begin
         if (fq.size() < 6 && $urandom_range(0, 3) == 0)
            load_packet(8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
         if ((c % 400) >= 360) out_ready = 1'b0;
         else out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 400 && (fq.size() != 0 || exp_q.size() != 0); c++) cycle();
      cycle();
      check("drain_fifo", fq.size(), 0);
      check("drain_scoreboard", exp_q.size(), 0);
      check("drain_idle", int'(valid_seen), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
